fx2_slavefifo_bridge: RTL and testbench
=======================================

FX2_SLAVEFIFO_BRIDGE -- requirements
Module: fx2_slavefifo_bridge

Interface
REQ-001 Parameter IDLE_PKTEND, default 16: count of consecutive idle WR cycles (no tx_valid) before a partial IN packet is committed.
REQ-002 Parameter PKT_SIZE, default 512: FX2 EP2 auto-commit packet size in bytes.
REQ-003 ifclk  input  1  sole clock, all logic on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 flaga  input  1  EP2 full flag, active low (0 = full).
REQ-006 flagb  input  1  EP6 empty flag, active low (0 = empty).
REQ-007 fd_i  input  8  FX2 data bus, sampled.
REQ-008 fd_o  output  8  FX2 data bus, driven value.
REQ-009 fd_oe  output  1  1 = top level drives fd_o onto fd.
REQ-010 sloe, slrd, slwr, pktend  output  1 each  FX2 strobes, active low.
REQ-011 fifoadr  output  2  FX2 FIFO select: 2'b10 = EP6 (OUT), 2'b00 = EP2 (IN).
REQ-012 rx_data  output  8  byte read from EP6.
REQ-013 rx_valid  output  1  rx_data valid.
REQ-014 rx_ready  input  1  consumer accepts rx_data.
REQ-015 tx_data  input  8  byte to write to EP2.
REQ-016 tx_valid  input  1  tx_data valid.
REQ-017 tx_ready  output  1  tx_data consumed this cycle.
REQ-018 tx_flush  input  1  request immediate commit of a partial IN packet.
REQ-019 busy  output  1  1 when state is not IDLE.

Function
REQ-020 The FSM SHALL have states IDLE, RD_TURN, RD, WR_TURN, WR and PKTEND.
REQ-021 IDLE exits: flagb=1 and rx_valid=0 -> RD_TURN; else tx_valid=1 -> WR_TURN; read has priority.
REQ-022 RD_TURN and WR_TURN SHALL last exactly one cycle, with all strobes high and fd_oe=0 (bus turnaround).
REQ-023 fifoadr SHALL be registered: 2'b10 in IDLE, RD_TURN and RD; 2'b00 in WR_TURN, WR and PKTEND.
REQ-024 sloe=0 only in RD_TURN and RD; fd_oe=1 only in WR and PKTEND.
REQ-025 RD: slrd=0 (combinational) when flagb=1 and (rx_valid=0 or rx_ready=1).
REQ-026 On the edge where slrd=0, fd_i SHALL load into rx_data and rx_valid SHALL be set; read latency is 1 cycle.
REQ-027 rx_valid SHALL clear on rx_ready=1 with no new read in the same cycle.
REQ-028 RD -> IDLE when flagb=0, with no byte lost.
REQ-029 WR: tx_ready = slwr_n_active = tx_valid & flaga; slwr=0 exactly when tx_ready=1; fd_o=tx_data.
REQ-030 A 9-bit byte counter SHALL increment per written byte and wrap to 0 at PKT_SIZE (FX2 auto-commit; no pktend).
REQ-031 An idle counter SHALL count WR cycles with tx_valid=0 and clear on any write.
REQ-032 WR -> PKTEND when byte count != 0 and either the idle counter reaches IDLE_PKTEND or tx_flush=1.
REQ-033 WR -> IDLE when tx_valid=0 and byte count = 0.
REQ-034 tx_flush with byte count = 0 SHALL be ignored.
REQ-035 PKTEND SHALL last one cycle with pktend=0 and slwr=1, then clear byte count and go to IDLE.
REQ-036 If tx_flush and a write coincide, the write SHALL complete first, and PKTEND follows on the next cycle.
REQ-037 When flaga=0 in WR, stall with tx_ready=0; the idle counter SHALL NOT advance while tx_valid=1.

Reset
REQ-038 On reset_n=0, state=IDLE, sloe/slrd/slwr/pktend=1, fifoadr=2'b10, fd_oe=0, fd_o=0, rx_valid=0, rx_data=0, counters=0.
REQ-039 Reset mid-packet SHALL abandon the partial packet and issue no pktend.

Verification
REQ-040 EP6 holds 3 bytes (A1, A2, A3), rx_ready=1 -> RD_TURN, then 3 slrd low pulses; rx_data A1, A2, A3 on consecutive cycles; IDLE once flagb=0.
REQ-041 rx_ready held 0 during a read -> exactly one byte read; slrd stays 1 until rx_ready=1; no byte duplicated or dropped.
REQ-042 5 tx bytes, then tx_valid=0 -> 5 slwr pulses, then 16 idle cycles, then one pktend=0 cycle, then IDLE.
REQ-043 512 continuous tx bytes with flaga=1 -> counter wraps to 0, no pktend, WR -> IDLE when tx_valid drops.
REQ-044 flaga=0 for 4 cycles mid-burst -> tx_ready=0 and slwr=1 throughout; no premature pktend; resumes on flaga=1.
REQ-045 Both sides request from IDLE (flagb=1, tx_valid=1) -> read serviced first; also reset_n pulsed after 3 written bytes -> outputs at reset values, no pktend.

Source files
------------

// File: rtl/fx2_slavefifo_bridge_if.sv
// fx2_slavefifo_bridge_if: FX2 slave-FIFO pins plus the rx/tx byte-stream handshakes.
interface fx2_slavefifo_bridge_if;
    logic       flaga;
    logic       flagb;
    logic [7:0] fd_i;
    logic [7:0] fd_o;
    logic       fd_oe;
    logic       sloe;
    logic       slrd;
    logic       slwr;
    logic       pktend;
    logic [1:0] fifoadr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_flush;
    logic       busy;
    modport master (
        input  flaga, flagb, fd_i, rx_ready, tx_data, tx_valid, tx_flush,
        output fd_o, fd_oe, sloe, slrd, slwr, pktend, fifoadr, rx_data, rx_valid, tx_ready, busy
    );
    modport slave (
        output flaga, flagb, fd_i, rx_ready, tx_data, tx_valid, tx_flush,
        input  fd_o, fd_oe, sloe, slrd, slwr, pktend, fifoadr, rx_data, rx_valid, tx_ready, busy
    );
endinterface

// File: rtl/fx2_slavefifo_bridge.sv
// fx2_slavefifo_bridge: Cypress FX2 slave-FIFO master; EP6 bytes to rx stream, tx stream to EP2 with idle/flush pktend.
module fx2_slavefifo_bridge #(
    parameter int IDLE_PKTEND = 16,
    parameter int PKT_SIZE    = 512
) (
    input  logic                   ifclk,
    input  logic                   reset_n,
    fx2_slavefifo_bridge_if.master bus
);
    localparam int IW = $clog2(IDLE_PKTEND + 1);
    typedef enum logic [2:0] {IDLE, RD_TURN, RD, WR_TURN, WR, PKTEND} state_t;
    state_t        state, state_nxt;
    logic [8:0]    byte_cnt, byte_nxt;
    logic [IW-1:0] idle_cnt, idle_nxt;
    logic          rd, wr;
    always_comb begin
        rd = state == RD && bus.flagb && (!bus.rx_valid || bus.rx_ready);
        wr = state == WR && bus.tx_valid && bus.flaga;
        byte_nxt = state == PKTEND ? '0 : wr ? (byte_cnt == 9'(PKT_SIZE - 1) ? '0 : byte_cnt + 9'd1) : byte_cnt;
        // a stalled write (tx_valid held, flaga low) neither advances nor clears the idle count
        idle_nxt = (state != WR || wr) ? '0 : !bus.tx_valid ? idle_cnt + IW'(1) : idle_cnt;
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.flagb && !bus.rx_valid ? RD_TURN : bus.tx_valid ? WR_TURN : IDLE;
            RD_TURN: state_nxt = RD;
            RD:      state_nxt = bus.flagb ? RD : IDLE;
            WR_TURN: state_nxt = WR;
            WR:      state_nxt = byte_nxt != '0 && (bus.tx_flush || idle_nxt == IW'(IDLE_PKTEND)) ? PKTEND
                               : !bus.tx_valid && byte_cnt == '0 ? IDLE : WR;
            PKTEND:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        bus.slrd = !rd;
        bus.slwr = !wr;
        bus.tx_ready = wr;
        bus.sloe = !(state == RD_TURN || state == RD);
        bus.fd_oe = state == WR || state == PKTEND;
        bus.pktend = state != PKTEND;
        bus.fd_o = state == WR ? bus.tx_data : '0;
        bus.busy = state != IDLE;
    end
    always_ff @(posedge ifclk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            byte_cnt <= '0;
            idle_cnt <= '0;
            bus.fifoadr <= 2'b10;
            bus.rx_data <= '0;
            bus.rx_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            byte_cnt <= byte_nxt;
            idle_cnt <= idle_nxt;
            bus.fifoadr <= (state_nxt == WR_TURN || state_nxt == WR || state_nxt == PKTEND) ? 2'b00 : 2'b10;
            bus.rx_data <= rd ? bus.fd_i : bus.rx_data;
            bus.rx_valid <= rd || (bus.rx_valid && !bus.rx_ready);
        end
    end
endmodule

// File: tb/tb_fx2_slavefifo_bridge.sv
// tb_fx2_slavefifo_bridge: FX2 FIFO models (EP6 queue, EP2 capture) plus rx/tx stream scoreboards, directed then random.
module tb_fx2_slavefifo_bridge;
    localparam int IDLE_PKTEND = 16;
    localparam int PKT_SIZE    = 512;
    logic ifclk = 1'b0;
    logic reset_n = 1'b0;
    always #5 ifclk = ~ifclk;
    fx2_slavefifo_bridge_if bus();
    fx2_slavefifo_bridge #(.IDLE_PKTEND(IDLE_PKTEND), .PKT_SIZE(PKT_SIZE)) dut (
        .ifclk(ifclk), .reset_n(reset_n), .bus(bus)
    );
    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [7:0] ep6[$], exp_rx[$], tx_q[$];
    int rd_log[$], wr_log[$], pk_log[$];
    int wr_cnt = 0, rx_got = 0, last_pop = -1;
    logic tx_en = 1'b0, fa = 1'b1, rdy = 1'b0, flush = 1'b0;
    logic s_sloe, s_slrd, s_slwr, s_pktend, s_fd_oe, s_busy, s_rx_valid, s_tx_ready;
    logic [1:0] s_fifoadr;
    logic [7:0] s_rx_data, s_fd_o;
    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
    endtask
    task automatic step();
        bus.flagb = ep6.size() > 0;
        bus.fd_i = ep6.size() > 0 ? ep6[0] : 8'h00;
        bus.flaga = fa;
        bus.tx_valid = tx_en && tx_q.size() > 0;
        bus.tx_data = tx_q.size() > 0 ? tx_q[0] : 8'h00;
        bus.rx_ready = rdy;
        bus.tx_flush = flush;
        #4;
        s_sloe = bus.sloe; s_slrd = bus.slrd; s_slwr = bus.slwr; s_pktend = bus.pktend;
        s_fd_oe = bus.fd_oe; s_busy = bus.busy; s_rx_valid = bus.rx_valid; s_tx_ready = bus.tx_ready;
        s_fifoadr = bus.fifoadr; s_rx_data = bus.rx_data; s_fd_o = bus.fd_o;
        if (reset_n) begin
            if (last_pop >= 0) begin
                check("rd_latency_valid", s_rx_valid, 1);
                check("rd_latency_data", s_rx_data, last_pop);
            end
            last_pop = -1;
            check("slwr_eq_not_ready", s_slwr, !s_tx_ready);
            check("no_bus_contention", s_fd_oe && !s_sloe, 0);
            if (s_rx_valid && rdy) begin
                check("rx_expected", exp_rx.size() > 0, 1);
                if (exp_rx.size() > 0) begin
                    check("rx_data", s_rx_data, exp_rx.pop_front());
                    rx_got++;
                end
            end
            if (!s_slrd) begin
                check("rd_not_empty", ep6.size() > 0, 1);
                check("rd_sloe", s_sloe, 0);
                check("rd_fifoadr", s_fifoadr, 2'b10);
                if (ep6.size() > 0) begin
                    last_pop = ep6.pop_front();
                    exp_rx.push_back(8'(last_pop));
                end
                rd_log.push_back(cyc);
            end
            if (s_tx_ready) begin
                check("wr_has_data", tx_q.size() > 0 && tx_en && fa, 1);
                if (tx_q.size() > 0) check("wr_fd_o", s_fd_o, tx_q.pop_front());
                check("wr_fd_oe", s_fd_oe, 1);
                check("wr_fifoadr", s_fifoadr, 2'b00);
                wr_cnt = (wr_cnt + 1) % PKT_SIZE;
                wr_log.push_back(cyc);
            end
            if (!s_pktend) begin
                check("pktend_partial", wr_cnt != 0, 1);
                check("pktend_slwr", s_slwr, 1);
                check("pktend_fd_oe", s_fd_oe, 1);
                wr_cnt = 0;
                pk_log.push_back(cyc);
            end
        end else begin
            wr_cnt = 0;
            last_pop = -1;
            exp_rx.delete();
        end
        @(posedge ifclk);
        #1;
        cyc++;
    endtask
    task automatic check_reset();
        check("rst_sloe", s_sloe, 1);
        check("rst_slrd", s_slrd, 1);
        check("rst_slwr", s_slwr, 1);
        check("rst_pktend", s_pktend, 1);
        check("rst_fd_oe", s_fd_oe, 0);
        check("rst_fd_o", s_fd_o, 0);
        check("rst_fifoadr", s_fifoadr, 2'b10);
        check("rst_rx_valid", s_rx_valid, 0);
        check("rst_rx_data", s_rx_data, 0);
        check("rst_busy", s_busy, 0);
    endtask
    task automatic load_tx(int n);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
        rd_log.delete();
        wr_log.delete();
        pk_log.delete();
    endtask
    initial begin
        int t0, pushed_rx;
        repeat (2) step();
        check_reset();
        reset_n = 1'b1;
        step();
        // three-byte EP6 read with an always-ready consumer
        rdy = 1'b1;
        ep6 = '{8'hA1, 8'hA2, 8'hA3};
        rd_log.delete();
        rx_got = 0;
        t0 = cyc;
        step();
        check("rd_start_idle", s_busy, 0);
        step();
        check("rdturn_sloe", s_sloe, 0);
        check("rdturn_slrd", s_slrd, 1);
        check("rdturn_fd_oe", s_fd_oe, 0);
        repeat (5) step();
        check("rd_count", rd_log.size(), 3);
        if (rd_log.size() == 3) begin
            check("rd_first", rd_log[0] - t0, 2);
            check("rd_consecutive", rd_log[2] - rd_log[0], 2);
        end
        check("rd_rx_got", rx_got, 3);
        check("rd_back_idle", s_busy, 0);
        // consumer back-pressure: one byte only until rx_ready returns
        rdy = 1'b0;
        ep6 = '{8'hB1, 8'hB2};
        rd_log.delete();
        rx_got = 0;
        repeat (8) step();
        check("bp_one_read", rd_log.size(), 1);
        check("bp_slrd_high", s_slrd, 1);
        check("bp_rx_valid", s_rx_valid, 1);
        check("bp_rx_data", s_rx_data, 8'hB1);
        rdy = 1'b1;
        repeat (6) step();
        check("bp_reads", rd_log.size(), 2);
        check("bp_rx_got", rx_got, 2);
        check("bp_idle", s_busy, 0);
        // five bytes then idle timeout commit
        load_tx(5);
        tx_en = 1'b1;
        t0 = cyc;
        step();
        step();
        check("wrturn_slwr", s_slwr, 1);
        check("wrturn_fd_oe", s_fd_oe, 0);
        check("wrturn_fifoadr", s_fifoadr, 2'b00);
        repeat (23) step();
        check("idle_writes", wr_log.size(), 5);
        check("idle_pktends", pk_log.size(), 1);
        if (wr_log.size() == 5 && pk_log.size() == 1) begin
            check("idle_first_wr", wr_log[0] - t0, 2);
            check("idle_timeout", pk_log[0] - wr_log[4], IDLE_PKTEND + 1);
        end
        check("idle_back_idle", s_busy, 0);
        check("idle_fifoadr", s_fifoadr, 2'b10);
        // a full packet auto-commits on the wrap, no pktend
        load_tx(PKT_SIZE);
        t0 = cyc;
        repeat (PKT_SIZE + 4) step();
        check("wrap_writes", wr_log.size(), PKT_SIZE);
        check("wrap_no_pktend", pk_log.size(), 0);
        check("wrap_idle", s_busy, 0);
        repeat (20) step();
        check("wrap_still_no_pktend", pk_log.size(), 0);
        // EP2 full stalls, short and long
        for (int k = 0; k < 2; k++) begin
            load_tx(10);
            repeat (5) step();
            fa = 1'b0;
            for (int i = 0; i < (k ? 24 : 4); i++) begin
                step();
                check("full_tx_ready", s_tx_ready, 0);
                check("full_slwr", s_slwr, 1);
            end
            check("full_no_pktend", pk_log.size(), 0);
            fa = 1'b1;
            repeat (30) step();
            check("full_writes", wr_log.size(), 10);
            check("full_pktends", pk_log.size(), 1);
            if (wr_log.size() == 10 && pk_log.size() == 1)
                check("full_timeout", pk_log[0] - wr_log[9], IDLE_PKTEND + 1);
        end
        // flush coinciding with the last write, then flushes with nothing pending
        load_tx(3);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        repeat (2) step();
        check("flush_writes", wr_log.size(), 3);
        check("flush_pktends", pk_log.size(), 1);
        if (wr_log.size() == 3 && pk_log.size() == 1)
            check("flush_after_write", pk_log[0] - wr_log[2], 1);
        check("flush_idle", s_busy, 0);
        flush = 1'b1;
        repeat (5) step();
        check("flush_idle_ignored", pk_log.size(), 1);
        fa = 1'b0;
        load_tx(1);
        repeat (6) step();
        check("flush_empty_ignored", pk_log.size(), 0);
        check("flush_empty_busy", s_busy, 1);
        flush = 1'b0;
        fa = 1'b1;
        repeat (20) step();
        check("flush_resume_pktend", pk_log.size(), 1);
        if (wr_log.size() == 1 && pk_log.size() == 1)
            check("flush_resume_timeout", pk_log[0] - wr_log[0], IDLE_PKTEND + 1);
        // simultaneous read and write requests: read first
        ep6 = '{8'hC1, 8'hC2};
        load_tx(2);
        repeat (30) step();
        check("prio_reads", rd_log.size(), 2);
        check("prio_writes", wr_log.size(), 2);
        if (rd_log.size() == 2 && wr_log.size() == 2)
            check("prio_read_first", rd_log[1] < wr_log[0], 1);
        // reset after three written bytes abandons the packet
        load_tx(6);
        repeat (5) step();
        check("rst_mid_writes", wr_log.size(), 3);
        tx_en = 1'b0;
        tx_q.delete();
        reset_n = 1'b0;
        step();
        check_reset();
        reset_n = 1'b1;
        repeat (30) step();
        check("rst_no_pktend", pk_log.size(), 0);
        tx_en = 1'b1;
        load_tx(PKT_SIZE);
        repeat (PKT_SIZE + 25) step();
        check("rst_fresh_count", pk_log.size(), 0);
        check("rst_fresh_idle", s_busy, 0);
        // random traffic on both directions
        rd_log.delete();
        wr_log.delete();
        pk_log.delete();
        rx_got = 0;
        pushed_rx = 0;
        for (int i = 0; i < 3000; i++) begin
            if (ep6.size() < 4 && $urandom_range(0, 3) == 0) begin
                ep6.push_back(8'($urandom));
                pushed_rx++;
            end
            if (tx_q.size() < 8 && $urandom_range(0, 2) == 0) tx_q.push_back(8'($urandom));
            rdy = $urandom_range(0, 3) != 0;
            tx_en = $urandom_range(0, 4) != 0;
            fa = $urandom_range(0, 9) != 0;
            flush = $urandom_range(0, 29) == 0;
            step();
        end
        rdy = 1'b1;
        tx_en = 1'b1;
        fa = 1'b1;
        flush = 1'b0;
        for (int i = 0; i < 2000 && (ep6.size() > 0 || tx_q.size() > 0 || exp_rx.size() > 0 || wr_cnt != 0 || s_busy); i++)
            step();
        check("drain_ep6", ep6.size(), 0);
        check("drain_tx", tx_q.size(), 0);
        check("drain_rx", rx_got, pushed_rx);
        check("drain_commit", wr_cnt, 0);
        check("drain_idle", s_busy, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
